// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial bit-pattern detector with overlap mode,
// enable, synchronous clear and a saturating match counter.
module seq_detect_param #(
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1010,
  parameter int              CNT_W   = 8,
  localparam int             SW      = $clog2(PLEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_i,
  input  logic             en_i,
  input  logic             ovl_i,
  input  logic             clr_i,
  output logic             f_o,
  output logic [SW-1:0]    s_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [SW-1:0]    s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    nxt [2][PLEN+1];
  logic             full;
  // Longest pattern prefix that is a suffix of (first s pattern bits, b); PATTERN[PLEN-1] is received first.
  function automatic logic [SW-1:0] kmp(input int s, input logic b);
    kmp = '0;
    for (int k = 1; k <= PLEN && k <= s + 1; k++) begin
      logic ok;
      ok = b == PATTERN[PLEN-k];
      for (int j = 0; j < k - 1; j++) ok &= PATTERN[PLEN-1-(s+1-k+j)] == PATTERN[PLEN-1-j];
      if (ok) kmp = SW'(k);
    end
  endfunction
  for (genvar g = 0; g <= PLEN; g++) begin : g_nxt
    assign nxt[0][g] = kmp(g, 1'b0);
    assign nxt[1][g] = kmp(g, 1'b1);
  end
  // Non-overlapping restart from a full match behaves exactly like leaving state 0.
  always_comb begin
    full  = s_q == SW'(PLEN);
    s_d   = clr_i ? '0 : !en_i ? s_q : (s_q > SW'(PLEN)) ? '0 : nxt[x_i][(full && !ovl_i) ? SW'(0) : s_q];
    cnt_d = clr_i ? '0 : (en_i && s_d == SW'(PLEN) && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end
  assign f_o   = full;
  assign s_o   = s_q;
  assign cnt_o = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: three detector configurations driven by a common stream,
// checked every cycle against a history-based model plus literal expectations.
module tb_seq_detect_param;
  logic clk = 1'b0, rst_n = 1'b0, x = 1'b0, en = 1'b0, ovl = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;
  logic       f0, f1, f2;
  logic [2:0] s0, s1;
  logic [0:0] s2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  seq_detect_param u0 (.clk(clk), .rst_n(rst_n), .x_i(x), .en_i(en), .ovl_i(ovl), .clr_i(clr),
                       .f_o(f0), .s_o(s0), .cnt_o(c0));
  seq_detect_param #(.PLEN(4), .PATTERN(4'b1101), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .x_i(x),
                       .en_i(en), .ovl_i(ovl), .clr_i(clr), .f_o(f1), .s_o(s1), .cnt_o(c1));
  seq_detect_param #(.PLEN(1), .PATTERN(1'b1), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .x_i(x),
                       .en_i(en), .ovl_i(ovl), .clr_i(clr), .f_o(f2), .s_o(s2), .cnt_o(c2));
  int n_chk = 0, n_fail = 0;
  int pl [3] = '{4, 4, 1};
  logic [15:0] pt [3] = '{16'b1010, 16'b1101, 16'b1};
  int cm [3] = '{255, 255, 3};
  int m_st [3], m_cnt [3], m_hl [3];
  logic [63:0] m_h [3];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Longest k <= plen such that the newest k bits of history equal the first k pattern bits.
  function automatic int mstate(input logic [63:0] h, input int hl, input logic [15:0] p, input int plen);
    for (int k = plen; k >= 1; k--) begin
      bit ok;
      ok = k <= hl;
      for (int j = 0; j < k; j++) if (h[k-1-j] != p[plen-1-j]) ok = 0;
      if (ok) return k;
    end
    return 0;
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_hl[i] = 0; m_h[i] = '0;
    end
  endfunction
  function automatic void m_step();
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_st[i] = 0; m_cnt[i] = 0; m_hl[i] = 0;
      end else if (en) begin
        if (m_st[i] == pl[i] && !ovl) m_hl[i] = 0;
        m_h[i] = {m_h[i][62:0], x};
        if (m_hl[i] < 64) m_hl[i]++;
        m_st[i] = mstate(m_h[i], m_hl[i], pt[i], pl[i]);
        if (m_st[i] == pl[i] && m_cnt[i] < cm[i]) m_cnt[i]++;
      end
    end
  endfunction
  task automatic compare_all();
    chk("s0", int'(s0), m_st[0]); chk("f0", int'(f0), int'(m_st[0] == pl[0])); chk("cnt0", int'(c0), m_cnt[0]);
    chk("s1", int'(s1), m_st[1]); chk("f1", int'(f1), int'(m_st[1] == pl[1])); chk("cnt1", int'(c1), m_cnt[1]);
    chk("s2", int'(s2), m_st[2]); chk("f2", int'(f2), int'(m_st[2] == pl[2])); chk("cnt2", int'(c2), m_cnt[2]);
  endtask
  task automatic step(input logic xi, input logic ei, input logic oi, input logic ci);
    x = xi; en = ei; ovl = oi; clr = ci;
    @(posedge clk);
    m_step();
    #1;
    compare_all();
  endtask
  initial begin
    logic [7:0] bits;
    logic [4:0] b6;
    int exp_ov [8] = '{1, 2, 3, 4, 3, 4, 3, 4};
    int exp_no [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
    int exp_sat [6] = '{1, 2, 3, 3, 3, 3};
    int exp_fb [5] = '{1, 2, 2, 3, 4};
    int nf;
    m_reset();
    #12;
    chk("rst_s0", int'(s0), 0); chk("rst_f0", int'(f0), 0); chk("rst_cnt0", int'(c0), 0);
    chk("rst_s2", int'(s2), 0); chk("rst_cnt2", int'(c2), 0);
    rst_n = 1'b1;
    bits = 8'b10101010;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    nf = 0;
    for (int j = 0; j < 8; j++) begin
      step(bits[7-j], 1'b1, 1'b1, 1'b0);
      chk("ovl_s", int'(s0), exp_ov[j]);
      nf += int'(f0);
    end
    chk("ovl_fhigh", nf, 3); chk("ovl_cnt", int'(c0), 3);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    nf = 0;
    for (int j = 0; j < 8; j++) begin
      step(bits[7-j], 1'b1, 1'b0, 1'b0);
      chk("novl_s", int'(s0), exp_no[j]);
      nf += int'(f0);
    end
    chk("novl_fhigh", nf, 2); chk("novl_cnt", int'(c0), 2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("en_pre_s", int'(s0), 2);
    for (int j = 0; j < 3; j++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      chk("en_hold_s", int'(s0), 2); chk("en_hold_cnt", int'(c0), 2);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_s", int'(s0), 0); chk("clr_cnt", int'(c0), 0);
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("sat_cnt", int'(c2), exp_sat[j]);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    b6 = 5'b11101;
    for (int j = 0; j < 5; j++) begin
      step(b6[4-j], 1'b1, 1'b1, 1'b0);
      chk("fb_s", int'(s1), exp_fb[j]); chk("fb_f", int'(f1), int'(j == 4));
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 5; j++) step(bits[7-j], 1'b1, 1'b1, 1'b0);
    chk("pre_rst_s", int'(s0), 3); chk("pre_rst_cnt", int'(c0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s", int'(s0), 0); chk("arst_f", int'(f0), 0); chk("arst_cnt", int'(c0), 0);
    m_reset();
    x = 1'b1; en = 1'b1; ovl = 1'b1; clr = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_hold_s", int'(s0), 0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_rst_s", int'(s0), 1);
    for (int j = 0; j < 3000; j++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
